li_pipe_gen: RTL and testbench
==============================

LI_PIPE_GEN -- requirements
Module: li_pipe_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, payload width in bits (legal 1..64).
REQ-002 SHALL have parameter N_STAGES, default 2, number of pipeline stages (legal 0..16).
REQ-003 SHALL have parameter INTERCONNECT_TYPE, default "carloni", mode select (legal "non_li", "credit", "carloni").
REQ-004 SHALL have port clock, input, 1, single clock; all state rising-edge triggered.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset; 0 = reset asserted.
REQ-006 SHALL have port i_data, input, DATA_WIDTH, signed payload from sender.
REQ-007 SHALL have port i_valid, input, 1, sender payload valid.
REQ-008 SHALL have port o_li_feedback, output, 1, to sender: stop (carloni), credit-return pulse (credit), constant 0 (non_li).
REQ-009 SHALL have port o_data, output, DATA_WIDTH, signed payload to receiver.
REQ-010 SHALL have port o_valid, output, 1, receiver payload valid.
REQ-011 SHALL have port i_li_feedback, input, 1, from receiver: stop (carloni), credit-return pulse (credit), ignored (non_li).
REQ-012 SHALL have port o_occupancy, output, $clog2(2*N_STAGES+1) (min 1), number of valid words held in the block.

Function
REQ-013 With N_STAGES=0, o_data=i_data, o_valid=i_valid, o_li_feedback=i_li_feedback (0 in non_li), o_occupancy=0, all combinational.
REQ-014 non_li: N_STAGES plain registers on {data, valid}; latency exactly N_STAGES cycles; no stall ever; o_li_feedback=0.
REQ-015 credit: forward {data, valid} delayed N_STAGES cycles; i_li_feedback delayed N_STAGES cycles onto o_li_feedback through an independent reverse register chain; each credit pulse preserved one-for-one, back-to-back pulses not merged.
REQ-016 non_li/credit: o_occupancy = count of stage registers holding valid=1.
REQ-017 carloni: chain of N_STAGES relay stations; stage k input side connects to stage k-1 output side; stage 0 to sender ports, stage N_STAGES-1 to receiver ports.
REQ-018 Each relay station: two-entry FIFO (main, aux) with 2-bit count register cnt in {0,1,2}; cnt=3 unreachable.
REQ-019 Station stop_up = (cnt==2), decoded from the register only; no combinational path from i_li_feedback to o_li_feedback when N_STAGES>=1.
REQ-020 Station accept = up_valid && !stop_up; emit = (cnt>0) && !stop_down; cnt_next = cnt + accept - emit.
REQ-021 Station down_valid = (cnt>0); down_data = oldest entry (main); on emit with cnt==2, aux moves to main same edge.
REQ-022 Simultaneous accept and emit at cnt==1: new word replaces main, cnt stays 1; at cnt==2 accept is impossible.
REQ-023 Unstalled carloni: one word per cycle sustained, latency N_STAGES cycles, every station cnt<=1.
REQ-024 Sender words offered while o_li_feedback=1 are not accepted; sender must hold them.
REQ-025 Stall propagation: stop ripples upstream one stage per cycle; no word lost or duplicated; order preserved.
REQ-026 carloni: o_occupancy = sum of all station cnt values, max 2*N_STAGES.
REQ-027 o_data undefined-but-stable while o_valid=0; receiver SHALL qualify with o_valid.
REQ-028 Illegal INTERCONNECT_TYPE SHALL fail elaboration.

Reset
REQ-029 reset=0 SHALL immediately clear all valid bits, cnt registers and reverse credit chain regardless of clock.
REQ-030 During and after reset: o_valid=0, o_li_feedback=0, o_occupancy=0; data registers reset to 0.
REQ-031 Reset mid-operation SHALL discard in-flight words and credits; first accepted word after release appears after N_STAGES cycles.

Verification
REQ-032 non_li, N=3, i_valid=1 with data 1,2,3,... from cycle 0 -> o_valid rises cycle 3, o_data 1,2,3,... one per cycle, o_occupancy=3 steady.
REQ-033 credit, N=2, i_li_feedback pulses cycles 5 and 6 -> o_li_feedback high cycles 7 and 8, two distinct pulses.
REQ-034 carloni, N=2, stream 10..20, i_li_feedback=1 cycles 6-9 -> o_li_feedback high from cycle 8 (two-stage ripple), o_occupancy peaks at 4, output order 10..20 intact, no gaps beyond stall.
REQ-035 carloni, N=4, i_li_feedback held 1, i_valid=1 -> exactly 8 words accepted, o_li_feedback=1, o_occupancy=8, cnt never exceeds 2.
REQ-036 carloni, N=2, reset=0 asserted asynchronously mid-stall with occupancy 3 -> o_valid, o_li_feedback, o_occupancy 0 before next clock edge; post-release word 0x55 out after 2 cycles.
REQ-037 Any mode, N=0, random i_data/i_valid/i_li_feedback -> outputs equal inputs in the same cycle.

Source files
------------

// File: rtl/li_pipe_gen.sv
// Latency-insensitive pipeline generator. Builds a plain register chain (non_li),
// a forward/reverse credit chain (credit) or a chain of Carloni relay stations.

module li_relay_station #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] up_data_i,
  input  logic                  up_valid_i,
  output logic                  up_stop_o,
  output logic [DATA_WIDTH-1:0] dn_data_o,
  output logic                  dn_valid_o,
  input  logic                  dn_stop_i,
  output logic [1:0]            cnt_o
);
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] main_q, main_d, aux_q, aux_d;
  logic                  accept, emit;

  // Stop is a pure register decode so stop never races through a station.
  assign up_stop_o  = (cnt_q == 2'd2);
  assign accept     = up_valid_i && !up_stop_o;
  assign emit       = (cnt_q != 2'd0) && !dn_stop_i;
  assign dn_valid_o = (cnt_q != 2'd0);
  assign dn_data_o  = main_q;
  assign cnt_o      = cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    main_d = main_q;
    aux_d  = aux_q;
    unique case ({accept, emit})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) main_d = up_data_i;
        else               aux_d  = up_data_i;
      end
      2'b01: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd2) main_d = aux_q;
      end
      2'b11:   main_d = up_data_i;  // only possible at cnt==1
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      main_q <= '0;
      aux_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      main_q <= main_d;
      aux_q  <= aux_d;
    end
  end
endmodule

module li_pipe_gen #(
  parameter int    DATA_WIDTH        = 16,
  parameter int    N_STAGES          = 2,
  parameter string INTERCONNECT_TYPE = "carloni",
  localparam int   OCC_W             = (N_STAGES == 0) ? 1 : $clog2(2*N_STAGES+1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_valid,
  output logic                         o_li_feedback,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  input  logic                         i_li_feedback,
  output logic [OCC_W-1:0]             o_occupancy
);
  localparam bit IS_NON_LI  = (INTERCONNECT_TYPE == "non_li");
  localparam bit IS_CREDIT  = (INTERCONNECT_TYPE == "credit");
  localparam bit IS_CARLONI = (INTERCONNECT_TYPE == "carloni");

  if (!(IS_NON_LI || IS_CREDIT || IS_CARLONI)) begin : g_bad_type
    $fatal(1, "li_pipe_gen: INTERCONNECT_TYPE must be non_li, credit or carloni");
  end

  if (N_STAGES == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl    = clock ^ reset ^ i_li_feedback;
    assign o_data        = i_data;
    assign o_valid       = i_valid;
    assign o_li_feedback = IS_NON_LI ? 1'b0 : i_li_feedback;
    assign o_occupancy   = '0;
  end else if (IS_CARLONI) begin : g_carloni
    // Index k is the boundary in front of station k; N_STAGES is the receiver side.
    wire [N_STAGES:0][DATA_WIDTH-1:0] st_data;
    wire [N_STAGES:0]                 st_valid;
    wire [N_STAGES:0]                 st_stop;
    wire [N_STAGES-1:0][1:0]          st_cnt;

    assign st_data[0]        = i_data;
    assign st_valid[0]       = i_valid;
    assign st_stop[N_STAGES] = i_li_feedback;
    assign o_data            = st_data[N_STAGES];
    assign o_valid           = st_valid[N_STAGES];
    assign o_li_feedback     = st_stop[0];

    for (genvar k = 0; k < N_STAGES; k++) begin : g_rs
      li_relay_station #(.DATA_WIDTH(DATA_WIDTH)) u_rs (
        .clock      (clock),
        .reset      (reset),
        .up_data_i  (st_data[k]),
        .up_valid_i (st_valid[k]),
        .up_stop_o  (st_stop[k]),
        .dn_data_o  (st_data[k+1]),
        .dn_valid_o (st_valid[k+1]),
        .dn_stop_i  (st_stop[k+1]),
        .cnt_o      (st_cnt[k])
      );
    end

    always_comb begin
      o_occupancy = '0;
      for (int k = 0; k < N_STAGES; k++) o_occupancy = o_occupancy + OCC_W'(st_cnt[k]);
    end
  end else begin : g_regs
    logic [N_STAGES-1:0][DATA_WIDTH-1:0] data_q;
    logic [N_STAGES-1:0]                 vld_q;
    logic [N_STAGES:0][DATA_WIDTH-1:0]   data_pipe;
    logic [N_STAGES:0]                   vld_pipe;

    assign data_pipe = {data_q, i_data};
    assign vld_pipe  = {vld_q, i_valid};
    assign o_data    = data_pipe[N_STAGES];
    assign o_valid   = vld_pipe[N_STAGES];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        data_q <= '0;
        vld_q  <= '0;
      end else begin
        data_q <= data_pipe[N_STAGES-1:0];
        vld_q  <= vld_pipe[N_STAGES-1:0];
      end
    end

    always_comb begin
      o_occupancy = '0;
      for (int k = 0; k < N_STAGES; k++) o_occupancy = o_occupancy + OCC_W'(vld_q[k]);
    end

    if (IS_CREDIT) begin : g_crd
      // Independent reverse chain: one bit per stage keeps adjacent pulses distinct.
      logic [N_STAGES-1:0] crd_q;
      logic [N_STAGES:0]   crd_pipe;
      assign crd_pipe      = {crd_q, i_li_feedback};
      assign o_li_feedback = crd_pipe[N_STAGES];
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) crd_q <= '0;
        else        crd_q <= crd_pipe[N_STAGES-1:0];
      end
    end else begin : g_nofb
      logic unused_fb;
      assign unused_fb     = i_li_feedback;
      assign o_li_feedback = 1'b0;
    end
  end
endmodule

// File: tb/tb_li_pipe_gen.sv
// Scoreboard bench for li_pipe_gen: five instances covering non_li, credit,
// carloni N=2/N=4 and the N=0 pass-through.
module tb_li_pipe_gen;
  localparam int DW = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [DW-1:0] nl_id, nl_od, cr_id, cr_od, c2_id, c2_od, c4_id, c4_od, z_id, z_od;
  logic nl_iv, nl_ov, nl_ifb, nl_ofb;
  logic cr_iv, cr_ov, cr_ifb, cr_ofb;
  logic c2_iv, c2_ov, c2_ifb, c2_ofb;
  logic c4_iv, c4_ov, c4_ifb, c4_ofb;
  logic z_iv, z_ov, z_ifb, z_ofb;
  logic [2:0] nl_occ, cr_occ, c2_occ;
  logic [3:0] c4_occ;
  logic [0:0] z_occ;

  li_pipe_gen #(.DATA_WIDTH(DW), .N_STAGES(3), .INTERCONNECT_TYPE("non_li")) u_nl (
    .clock(clock), .reset(reset), .i_data(nl_id), .i_valid(nl_iv), .o_li_feedback(nl_ofb),
    .o_data(nl_od), .o_valid(nl_ov), .i_li_feedback(nl_ifb), .o_occupancy(nl_occ));
  li_pipe_gen #(.DATA_WIDTH(DW), .N_STAGES(2), .INTERCONNECT_TYPE("credit")) u_cr (
    .clock(clock), .reset(reset), .i_data(cr_id), .i_valid(cr_iv), .o_li_feedback(cr_ofb),
    .o_data(cr_od), .o_valid(cr_ov), .i_li_feedback(cr_ifb), .o_occupancy(cr_occ));
  li_pipe_gen #(.DATA_WIDTH(DW), .N_STAGES(2), .INTERCONNECT_TYPE("carloni")) u_c2 (
    .clock(clock), .reset(reset), .i_data(c2_id), .i_valid(c2_iv), .o_li_feedback(c2_ofb),
    .o_data(c2_od), .o_valid(c2_ov), .i_li_feedback(c2_ifb), .o_occupancy(c2_occ));
  li_pipe_gen #(.DATA_WIDTH(DW), .N_STAGES(4), .INTERCONNECT_TYPE("carloni")) u_c4 (
    .clock(clock), .reset(reset), .i_data(c4_id), .i_valid(c4_iv), .o_li_feedback(c4_ofb),
    .o_data(c4_od), .o_valid(c4_ov), .i_li_feedback(c4_ifb), .o_occupancy(c4_occ));
  li_pipe_gen #(.DATA_WIDTH(DW), .N_STAGES(0), .INTERCONNECT_TYPE("carloni")) u_z (
    .clock(clock), .reset(reset), .i_data(z_id), .i_valid(z_iv), .o_li_feedback(z_ofb),
    .o_data(z_od), .o_valid(z_ov), .i_li_feedback(z_ifb), .o_occupancy(z_occ));

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] nl_q[$], cr_q[$], c2_q[$], c4_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected word 0x%0h with empty scoreboard", name, act);
  endtask

  // Monitor: every transferred output word must match the oldest issued word.
  always @(negedge clock) begin
    if (reset) begin
      if (nl_ov) begin
        if (nl_q.size() == 0) note_fail("nl_extra", nl_od);
        else chk("nl_data", nl_od, nl_q.pop_front());
      end
      if (cr_ov) begin
        if (cr_q.size() == 0) note_fail("cr_extra", cr_od);
        else chk("cr_data", cr_od, cr_q.pop_front());
      end
      if (c2_ov && !c2_ifb) begin
        if (c2_q.size() == 0) note_fail("c2_extra", c2_od);
        else chk("c2_data", c2_od, c2_q.pop_front());
      end
      if (c4_ov && !c4_ifb) begin
        if (c4_q.size() == 0) note_fail("c4_extra", c4_od);
        else chk("c4_data", c4_od, c4_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int c2_occ_exp [13] = '{0, 1, 2, 2, 2, 2, 2, 3, 4, 4, 4, 3, 2};
  int c2_next, c2_issued, c2_peak, c4_next, c4_issued, c4_acc;

  initial begin
    reset = 1'b0;
    {nl_id, cr_id, c2_id, c4_id, z_id} = '0;
    {nl_ifb, cr_ifb, c2_ifb, c4_ifb, z_iv, z_ifb} = '0;
    // Activity on the inputs while held in reset must not leak through.
    {nl_iv, cr_iv, c2_iv, c4_iv} = 4'hf;
    cr_ifb = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_nl", {nl_ov, nl_ofb, nl_occ}, '0);
    chk("rst_cr", {cr_ov, cr_ofb, cr_occ}, '0);
    chk("rst_c2", {c2_ov, c2_ofb, c2_occ}, '0);
    chk("rst_c4", {c4_ov, c4_ofb, c4_occ}, '0);
    {nl_iv, cr_iv, c2_iv, c4_iv, cr_ifb} = '0;
    reset = 1'b1;
    @(posedge clock); #1;

    // Phase 1: non_li N=3 stream, credit N=2 pulses, carloni N=2 stall 6-9.
    c2_next = 10; c2_issued = 9; c2_peak = 0;
    for (int c = 0; c < 26; c++) begin
      nl_iv  = (c < 10);
      nl_id  = nl_iv ? DW'(c + 1) : '0;
      nl_ifb = c[0];
      if (nl_iv) nl_q.push_back(DW'(c + 1));
      cr_iv  = (c == 1 || c == 2 || c == 4);
      cr_id  = DW'(16'h100 + c);
      cr_ifb = (c == 5 || c == 6);
      if (cr_iv) cr_q.push_back(DW'(16'h100 + c));
      c2_ifb = (c >= 6 && c <= 9);
      c2_iv  = (c2_next <= 20);
      c2_id  = DW'(c2_next);
      if (c2_iv && c2_next > c2_issued) begin
        c2_q.push_back(DW'(c2_next));
        c2_issued = c2_next;
      end
      @(negedge clock);
      if (c <= 14) chk("nl_valid_latency", nl_ov, (c >= 3 && c <= 12));
      if (c >= 3 && c <= 9) chk("nl_occ", nl_occ, 3);
      if (c == 5) chk("nl_fb_zero", nl_ofb, 0);
      if (c == 3) chk("cr_occ", cr_occ, 2);
      if (c <= 12) chk("cr_fb_delay", cr_ofb, (c == 7 || c == 8));
      if (c <= 13) chk("c2_stop", c2_ofb, (c >= 8 && c <= 11));
      if (c <= 12) chk("c2_occ", c2_occ, c2_occ_exp[c]);
      if (int'(c2_occ) > c2_peak) c2_peak = int'(c2_occ);
      if (c2_iv && !c2_ofb) c2_next++;
      @(posedge clock); #1;
    end
    chk("c2_occ_peak", c2_peak, 4);
    chk("nl_drained", nl_q.size(), 0);
    chk("cr_drained", cr_q.size(), 0);
    chk("c2_drained", c2_q.size(), 0);
    {nl_iv, cr_iv, c2_iv, nl_ifb, cr_ifb, c2_ifb} = '0;

    // Phase 2: carloni N=4 fully stalled, then drained.
    c4_next = 100; c4_issued = 99; c4_acc = 0;
    for (int c = 0; c < 50; c++) begin
      c4_ifb = (c < 20);
      c4_iv  = (c4_next <= 111);
      c4_id  = DW'(c4_next);
      if (c4_iv && c4_next > c4_issued) begin
        c4_q.push_back(DW'(c4_next));
        c4_issued = c4_next;
      end
      @(negedge clock);
      if (c == 19) begin
        chk("c4_accepted_full", c4_acc, 8);
        chk("c4_stop_full", c4_ofb, 1);
        chk("c4_occ_full", c4_occ, 8);
        chk("c4_head", {c4_ov, c4_od}, {1'b1, 16'd100});
      end
      if (c4_iv && !c4_ofb) begin
        c4_acc++;
        c4_next++;
      end
      @(posedge clock); #1;
    end
    chk("c4_accepted_total", c4_acc, 12);
    chk("c4_drained", c4_q.size(), 0);
    {c4_iv, c4_ifb} = '0;

    // Phase 3: carloni N=2 async reset while stalled with three words held.
    c2_ifb = 1'b1;
    for (int c = 0; c < 4; c++) begin
      c2_iv = (c < 3);
      c2_id = DW'(16'h30 + c);
      if (c2_iv) c2_q.push_back(DW'(16'h30 + c));
      @(negedge clock);
      if (c == 3) chk("c2_occ_pre_reset", c2_occ, 3);
      @(posedge clock); #1;
    end
    c2_iv = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("c2_async_reset", {c2_ov, c2_ofb, c2_occ}, '0);
    c2_q.delete();
    c2_ifb = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c < 4; c++) begin
      c2_iv = (c == 0);
      c2_id = c2_iv ? DW'(16'h55) : '0;
      if (c2_iv) c2_q.push_back(DW'(16'h55));
      @(negedge clock);
      if (c < 2) chk("c2_post_reset_idle", c2_ov, 0);
      if (c == 2) chk("c2_post_reset_word", {c2_ov, c2_od}, {1'b1, 16'h55});
      @(posedge clock); #1;
    end
    chk("c2_post_reset_drained", c2_q.size(), 0);

    // Phase 4: N=0 is purely combinational.
    for (int i = 0; i < 16; i++) begin
      z_id  = DW'($urandom);
      z_iv  = 1'($urandom);
      z_ifb = 1'($urandom);
      #2;
      chk("n0_passthrough", {z_od, z_ov, z_ofb, z_occ}, {z_id, z_iv, z_ifb, 1'b0});
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
